// File: rtl/instr_fmt_pkg.sv
// Shared RV32I encoding definitions for the instruction encoder (and decoder).
// Contents: instruction-format enum (also the decoder's imm_sel encoding),
// base opcode constants, the canonical nop word and a sign-extension helper.
package instr_fmt_pkg;

    typedef enum logic [2:0] {
        FmtI = 3'd0,
        FmtS = 3'd1,
        FmtB = 3'd2,
        FmtJ = 3'd3,
        FmtU = 3'd4,
        FmtR = 3'd5
    } instr_fmt_e;

    localparam logic [6:0] OpcLoad   = 7'h03;
    localparam logic [6:0] OpcStore  = 7'h23;
    localparam logic [6:0] OpcOp     = 7'h33;
    localparam logic [6:0] OpcBranch = 7'h63;
    localparam logic [6:0] OpcOpImm  = 7'h13;
    localparam logic [6:0] OpcJal    = 7'h6F;
    localparam logic [6:0] OpcJalr   = 7'h67;
    localparam logic [6:0] OpcLui    = 7'h37;

    // addi x0, x0, 0
    localparam logic [31:0] InstrNop = 32'h0000_0013;

    // True when v equals the sign-extension of its low (msb+1) bits.
    function automatic logic is_sext(input logic [31:0] v, input int unsigned msb);
        logic [31:0] ext;
        ext = 32'($signed(v << (31 - msb)) >>> (31 - msb));
        return ext == v;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with optional immediate range check.
// Ports: fmt/opcode/rd/rs1/rs2/funct3/funct7/imm field inputs;
//        instr = packed word (nop for an illegal fmt), err = illegal fmt or
//        (with INSTR_ENC_RANGE_CHECK_EN defined) immediate not representable.
module instr_pack
    import instr_fmt_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    logic illegal;
    logic range_err;

    always_comb begin
        instr   = InstrNop;
        illegal = 1'b0;
        case (fmt)
            FmtR: instr = {funct7, rs2, rs1, funct3, rd, opcode};
            FmtI: instr = {imm[11:0], rs1, funct3, rd, opcode};
            FmtS: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FmtB: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FmtU: instr = {imm[31:12], rd, opcode};
            FmtJ: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: illegal = 1'b1;
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // The word is still packed from truncated bits; only the flag reports it.
    always_comb begin
        range_err = 1'b0;
        case (fmt)
            FmtI, FmtS: range_err = !is_sext(imm, 11);
            FmtB:       range_err = !is_sext(imm, 12) || imm[0];
            FmtJ:       range_err = !is_sext(imm, 20) || imm[0];
            FmtU:       range_err = |imm[11:0];
            default:    range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    assign err = illegal | range_err;

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: valid/ready field input, single-entry
// registered output stage carrying the packed word, its word address and an
// error flag.
// Ports: clk, rst (async active-high); in_valid/in_ready + in_* fields;
//        cnt_clr (sync address-counter clear); out_valid/out_ready +
//        out_instr/out_addr/out_err.
// Optional feature: INSTR_ENC_RANGE_CHECK_EN enables immediate range errors.
module instr_encoder
    import instr_fmt_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              cnt_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic              out_err_q,   out_err_d;
    logic [ADDR_W-1:0] cnt_q,       cnt_d;

    logic [31:0] pack_instr;
    logic        pack_err;
    logic        accept;

    instr_pack u_pack (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .instr  (pack_instr),
        .err    (pack_err)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        cnt_d       = cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = pack_instr;
            out_err_d   = pack_err;
            // A clear coinciding with an accept tags this word with 0.
            out_addr_d  = cnt_clr ? '0 : cnt_q;
            cnt_d       = cnt_clr ? ADDR_W'(1) : cnt_q + ADDR_W'(1);
        end else begin
            if (out_ready) begin
                out_valid_d = 1'b0;
            end
            if (cnt_clr) begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            out_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (ADDR_W=2 so wrap is reachable).
module tb_instr_encoder;

    localparam int unsigned AW = 2;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_fmt = '0;
    logic [6:0]    in_opcode = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [31:0]   in_imm = '0;
    logic          cnt_clr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          out_err;

    int n_cmp = 0;
    int n_err = 0;

    vec_t vecs[$];

    instr_encoder #(.ADDR_W(AW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .cnt_clr   (cnt_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm,
                       input logic [31:0] exp_instr, input logic exp_err);
        vec_t v;
        v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_instr = exp_instr; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic set_in(input vec_t v);
        in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] held_instr;
        logic [AW-1:0] exp_addr;

        //   fmt   op     rd  rs1 rs2 f3  f7     imm           instr         err
        add(3'd0, 7'h13, 1,  0,  0,  0,  7'h00, 32'h0000_0005, 32'h0050_0093, 1'b0); // addi
        add(3'd1, 7'h23, 0,  1,  2,  2,  7'h00, 32'h0000_0008, 32'h0020_A423, 1'b0); // sw
        add(3'd2, 7'h63, 0,  0,  0,  0,  7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0); // beq
        add(3'd3, 7'h6F, 1,  0,  0,  0,  7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0); // jal
        add(3'd4, 7'h37, 5,  0,  0,  0,  7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0); // lui
        add(3'd5, 7'h33, 3,  1,  2,  0,  7'h00, 32'hFFFF_FFFF, 32'h0020_81B3, 1'b0); // add
        add(3'd5, 7'h33, 3,  1,  2,  0,  7'h20, 32'h0000_0000, 32'h4020_81B3, 1'b0); // sub
        add(3'd0, 7'h67, 0,  1,  0,  0,  7'h00, 32'hFFFF_FFFF, 32'hFFF0_8067, 1'b0); // jalr -1
        add(3'd1, 7'h23, 0,  1,  2,  2,  7'h00, 32'hFFFF_F800, 32'h8020_A023, 1'b0); // sw -2048
        add(3'd7, 7'h33, 3,  1,  2,  0,  7'h00, 32'h0000_0000, 32'h0000_0013, 1'b1); // fmt 7
        add(3'd6, 7'h13, 1,  1,  1,  1,  7'h7F, 32'h0000_0001, 32'h0000_0013, 1'b1); // fmt 6
        add(3'd0, 7'h13, 1,  0,  0,  0,  7'h00, 32'h0000_0800, 32'h8000_0093, RC);   // I 0x800
        add(3'd2, 7'h63, 0,  0,  0,  0,  7'h00, 32'h0000_0001, 32'h0000_0063, RC);   // B odd
        add(3'd4, 7'h37, 0,  0,  0,  0,  7'h00, 32'h1234_5678, 32'h1234_5037, RC);   // U low
        add(3'd3, 7'h6F, 0,  0,  0,  0,  7'h00, 32'h0010_0000, 32'h8000_006F, RC);   // J range

        // Reset state, including in_ready while reset is held.
        rst = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Table: back-to-back accepts with out_ready held high.
        do_reset();
        out_ready = 1'b1;
        exp_addr  = '0;
        foreach (vecs[i]) begin
            set_in(vecs[i]);
            in_valid = 1'b1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_instr", i), out_instr, vecs[i].exp_instr);
            chk($sformatf("v%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_addr", i), 32'(out_addr), 32'(exp_addr));
            exp_addr = exp_addr + 1'b1;
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // beq then jal back-to-back after reset: addrs 0 and 1.
        do_reset();
        set_in(vecs[2]);
        in_valid = 1'b1;
        tick();
        chk("beq_instr", out_instr, 32'hFE00_0EE3);
        chk("beq_addr", 32'(out_addr), 32'd0);
        chk("beq_in_ready", 32'(in_ready), 32'd1);
        set_in(vecs[3]);
        tick();
        chk("jal_instr", out_instr, 32'h0010_00EF);
        chk("jal_addr", 32'(out_addr), 32'd1);
        chk("jal_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        tick();

        // Backpressure: word held stable, next input stalled for 3 cycles.
        do_reset();
        out_ready = 1'b0;
        set_in(vecs[0]);
        in_valid = 1'b1;
        tick();
        held_instr = 32'h0050_0093;
        set_in(vecs[1]);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_instr", c), out_instr, held_instr);
            chk($sformatf("bp%0d_addr", c), 32'(out_addr), 32'd0);
            chk($sformatf("bp%0d_err", c), 32'(out_err), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_next_instr", out_instr, 32'h0020_A423);
        chk("bp_next_addr", 32'(out_addr), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_drain_valid", 32'(out_valid), 32'd0);

        // Wrap and clear.
        do_reset();
        set_in(vecs[0]);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("wrap%0d_addr", k), 32'(out_addr), 32'(k % 4));
        end
        cnt_clr = 1'b1;
        tick();
        chk("clr_accept_addr", 32'(out_addr), 32'd0);
        cnt_clr = 1'b0;
        tick();
        chk("after_clr_addr", 32'(out_addr), 32'd1);
        // Clear with no accept (counter was 2).
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        tick();
        cnt_clr  = 1'b0;
        in_valid = 1'b1;
        tick();
        chk("clr_idle_addr", 32'(out_addr), 32'd0);
        in_valid = 1'b0;
        tick();

        // Clear during backpressure still clears the counter.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("bp_clr_held_addr", 32'(out_addr), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_clr_next_addr", 32'(out_addr), 32'd0);
        in_valid = 1'b0;
        tick();

        // Async reset drops a held word before the next clock edge.
        do_reset();
        out_ready = 1'b0;
        set_in(vecs[0]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("held_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_instr", out_instr, 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
